// File: rtl/ghr_pkg.sv
// Shared defaults and sizing helpers for the speculative global history register
// and its checkpoint FIFO.
package ghr_pkg;

  localparam int HIST_W_DEFAULT     = 8;
  localparam int CKPT_DEPTH_DEFAULT = 4;

  // Occupancy counters need one extra bit so that "full" is distinct from "empty".
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ghr_ckpt_fifo.sv
// Circular FIFO of history checkpoints, one per in-flight branch.
// Callers must not push when full or pop when empty; clear wins over push and pop.
module ghr_ckpt_fifo
  import ghr_pkg::*;
#(
  parameter int W     = HIST_W_DEFAULT,
  parameter int DEPTH = CKPT_DEPTH_DEFAULT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [W-1:0]                  push_data,
  input  logic                          pop,
  input  logic                          clear,
  output logic [W-1:0]                  head,
  output logic [count_width(DEPTH)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // DEPTH is a power of two, so the pointers wrap naturally at PW bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/spec_global_history.sv
// Speculative and architectural global branch history with checkpointed recovery
// on misprediction and rollback to the committed history on flush.
module spec_global_history
  import ghr_pkg::*;
#(
  parameter int HIST_W     = HIST_W_DEFAULT,
  parameter int CKPT_DEPTH = CKPT_DEPTH_DEFAULT
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               predict_valid,
  input  logic                               predict_taken,
  output logic                               predict_ready,
  input  logic                               resolve_valid,
  input  logic                               resolve_taken,
  input  logic                               resolve_mispredict,
  input  logic                               flush,
  output logic [HIST_W-1:0]                  hist,
  output logic [HIST_W-1:0]                  commit_hist,
  output logic [count_width(CKPT_DEPTH)-1:0] ckpt_count,
  output logic                               err_underflow
);

  localparam int CW = count_width(CKPT_DEPTH);

  logic              accept_predict;
  logic              resolve_ok;
  logic              recover;
  logic              underflow;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_clear;
  logic [HIST_W-1:0] ckpt_head;

  // Readiness is judged on the pre-pop count, so a full FIFO blocks a predict
  // even when a resolve frees a slot in the same cycle.
  assign predict_ready  = (ckpt_count != CW'(CKPT_DEPTH));
  assign accept_predict = predict_valid && predict_ready;
  assign resolve_ok     = resolve_valid && (ckpt_count != '0);
  assign underflow      = resolve_valid && (ckpt_count == '0);
  assign recover        = resolve_ok && resolve_mispredict;

  // Flush and misprediction both discard all younger checkpoints and any predict.
  always_comb begin
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    fifo_clear = 1'b0;
    if (flush || recover) begin
      fifo_clear = 1'b1;
    end else begin
      fifo_push = accept_predict;
      fifo_pop  = resolve_ok;
    end
  end

  ghr_ckpt_fifo #(
    .W     (HIST_W),
    .DEPTH (CKPT_DEPTH)
  ) u_ckpt_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (hist),
    .pop       (fifo_pop),
    .clear     (fifo_clear),
    .head      (ckpt_head),
    .count     (ckpt_count)
  );

  // Recovery rebuilds history from the mispredicted branch's own checkpoint.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist <= '0;
    end else if (flush) begin
      hist <= commit_hist;
    end else if (recover) begin
      hist <= {ckpt_head[HIST_W-2:0], resolve_taken};
    end else if (accept_predict) begin
      hist <= {hist[HIST_W-2:0], predict_taken};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      commit_hist <= '0;
    end else if (!flush && resolve_ok) begin
      commit_hist <= {commit_hist[HIST_W-2:0], resolve_taken};
    end
  end

  // Sticky until reset so software can observe a lost resolve after the fact.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_underflow <= 1'b0;
    end else if (!flush && underflow) begin
      err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spec_global_history.sv
// Table-driven bench for spec_global_history (HIST_W=8, CKPT_DEPTH=4) with an
// expected-result queue filled at drive time and drained after each clock edge.
module tb_spec_global_history;

  logic       clk = 1'b0;
  logic       reset;
  logic       predict_valid, predict_taken, predict_ready;
  logic       resolve_valid, resolve_taken, resolve_mispredict, flush;
  logic [7:0] hist, commit_hist;
  logic [2:0] ckpt_count;
  logic       err_underflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       pv, pt, rv, rt, rm, fl;
    logic [7:0] eh, ec;
    logic [2:0] en;
    logic       er, ee;
  } vec_t;

  typedef struct {
    logic [7:0] h, c;
    logic [2:0] n;
    logic       r, e;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[18];

  spec_global_history #(.HIST_W(8), .CKPT_DEPTH(4)) dut (
    .clk                (clk),
    .reset              (reset),
    .predict_valid      (predict_valid),
    .predict_taken      (predict_taken),
    .predict_ready      (predict_ready),
    .resolve_valid      (resolve_valid),
    .resolve_taken      (resolve_taken),
    .resolve_mispredict (resolve_mispredict),
    .flush              (flush),
    .hist               (hist),
    .commit_hist        (commit_hist),
    .ckpt_count         (ckpt_count),
    .err_underflow      (err_underflow)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic pv, pt, rv, rt, rm, fl,
                              input logic [7:0] eh, ec, input logic [2:0] en,
                              input logic er, ee);
    vec_t v;
    v.pv = pv; v.pt = pt; v.rv = rv; v.rt = rt; v.rm = rm; v.fl = fl;
    v.eh = eh; v.ec = ec; v.en = en; v.er = er; v.ee = ee;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_now(input string tag, input exp_t e);
    cmp({tag, ".hist"}, hist, e.h);
    cmp({tag, ".commit_hist"}, commit_hist, e.c);
    cmp({tag, ".ckpt_count"}, {5'b0, ckpt_count}, {5'b0, e.n});
    cmp({tag, ".predict_ready"}, {7'b0, predict_ready}, {7'b0, e.r});
    cmp({tag, ".err_underflow"}, {7'b0, err_underflow}, {7'b0, e.e});
  endtask

  task automatic check_output(input string tag);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s.queue: got empty scoreboard, expected one entry", tag);
    end else begin
      e = exp_q.pop_front();
      check_now(tag, e);
    end
  endtask

  task automatic apply_stimulus(input string tag, input vec_t v);
    exp_t e;
    predict_valid      = v.pv;
    predict_taken      = v.pt;
    resolve_valid      = v.rv;
    resolve_taken      = v.rt;
    resolve_mispredict = v.rm;
    flush              = v.fl;
    e.h = v.eh; e.c = v.ec; e.n = v.en; e.r = v.er; e.e = v.ee;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    predict_valid = 1'b0; resolve_valid = 1'b0; flush = 1'b0;
    check_output(tag);
  endtask

  task automatic do_reset();
    exp_t z;
    z.h = 8'h00; z.c = 8'h00; z.n = 3'd0; z.r = 1'b1; z.e = 1'b0;
    reset = 1'b1;
    #1;
    check_now("reset", z);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    exp_t z;
    reset = 1'b0;
    predict_valid = 0; predict_taken = 0; resolve_valid = 0;
    resolve_taken = 0; resolve_mispredict = 0; flush = 0;

    //            pv pt rv rt rm fl  hist   commit  cnt rdy err
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 3'd0, 1, 0);
    vecs[1]  = mk(1, 1, 0, 0, 0, 0, 8'h01, 8'h00, 3'd1, 1, 0);
    vecs[2]  = mk(1, 1, 0, 0, 0, 0, 8'h03, 8'h00, 3'd2, 1, 0);
    vecs[3]  = mk(1, 0, 0, 0, 0, 0, 8'h06, 8'h00, 3'd3, 1, 0);
    vecs[4]  = mk(1, 1, 0, 0, 0, 0, 8'h0D, 8'h00, 3'd4, 0, 0);
    vecs[5]  = mk(1, 1, 0, 0, 0, 0, 8'h0D, 8'h00, 3'd4, 0, 0);
    vecs[6]  = mk(1, 1, 1, 1, 0, 0, 8'h0D, 8'h01, 3'd3, 1, 0);
    vecs[7]  = mk(1, 1, 1, 1, 0, 0, 8'h1B, 8'h03, 3'd3, 1, 0);
    vecs[8]  = mk(0, 0, 1, 0, 0, 0, 8'h1B, 8'h06, 3'd2, 1, 0);
    vecs[9]  = mk(1, 1, 1, 1, 0, 0, 8'h37, 8'h0D, 3'd2, 1, 0);
    vecs[10] = mk(1, 1, 1, 0, 1, 0, 8'h1A, 8'h1A, 3'd0, 1, 0);
    vecs[11] = mk(1, 1, 0, 0, 0, 0, 8'h35, 8'h1A, 3'd1, 1, 0);
    vecs[12] = mk(1, 0, 0, 0, 0, 0, 8'h6A, 8'h1A, 3'd2, 1, 0);
    vecs[13] = mk(1, 1, 1, 1, 0, 1, 8'h1A, 8'h1A, 3'd0, 1, 0);
    vecs[14] = mk(0, 0, 1, 1, 0, 0, 8'h1A, 8'h1A, 3'd0, 1, 1);
    vecs[15] = mk(1, 1, 0, 0, 0, 0, 8'h35, 8'h1A, 3'd1, 1, 1);
    vecs[16] = mk(0, 0, 1, 1, 0, 0, 8'h35, 8'h35, 3'd0, 1, 1);
    vecs[17] = mk(1, 0, 1, 0, 1, 0, 8'h6A, 8'h35, 3'd1, 1, 1);

    do_reset();
    for (int i = 0; i < 18; i++) apply_stimulus($sformatf("vec%0d", i), vecs[i]);

    // Misprediction restores from the oldest checkpoint (0x00).
    do_reset();
    apply_stimulus("mp.p0", mk(1, 1, 0, 0, 0, 0, 8'h01, 8'h00, 3'd1, 1, 0));
    apply_stimulus("mp.p1", mk(1, 1, 0, 0, 0, 0, 8'h03, 8'h00, 3'd2, 1, 0));
    apply_stimulus("mp.p2", mk(1, 0, 0, 0, 0, 0, 8'h06, 8'h00, 3'd3, 1, 0));
    apply_stimulus("mp.res", mk(0, 0, 1, 0, 1, 0, 8'h00, 8'h00, 3'd0, 1, 0));

    // Flush returns to committed history and drops the same-cycle predict.
    do_reset();
    apply_stimulus("fl.p0", mk(1, 1, 0, 0, 0, 0, 8'h01, 8'h00, 3'd1, 1, 0));
    apply_stimulus("fl.r0", mk(0, 0, 1, 1, 0, 0, 8'h01, 8'h01, 3'd0, 1, 0));
    apply_stimulus("fl.p1", mk(1, 1, 0, 0, 0, 0, 8'h03, 8'h01, 3'd1, 1, 0));
    apply_stimulus("fl.p2", mk(1, 0, 0, 0, 0, 0, 8'h06, 8'h01, 3'd2, 1, 0));
    apply_stimulus("fl.p3", mk(1, 1, 0, 0, 0, 0, 8'h0D, 8'h01, 3'd3, 1, 0));
    apply_stimulus("fl.go", mk(1, 1, 0, 0, 0, 1, 8'h01, 8'h01, 3'd0, 1, 0));

    // Sticky underflow, then asynchronous reset in the middle of a burst.
    apply_stimulus("uf.r", mk(0, 0, 1, 0, 0, 0, 8'h01, 8'h01, 3'd0, 1, 1));
    apply_stimulus("uf.p0", mk(1, 1, 0, 0, 0, 0, 8'h03, 8'h01, 3'd1, 1, 1));
    apply_stimulus("uf.p1", mk(1, 1, 0, 0, 0, 0, 8'h07, 8'h01, 3'd2, 1, 1));
    predict_valid = 1'b1; predict_taken = 1'b1;
    #3;
    reset = 1'b1;
    #1;
    z.h = 8'h00; z.c = 8'h00; z.n = 3'd0; z.r = 1'b1; z.e = 1'b0;
    check_now("async_rst", z);
    predict_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    apply_stimulus("post.idle", mk(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 3'd0, 1, 0));

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL leftover: got %0d entries, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spec_global_history.md
SPEC_GLOBAL_HISTORY -- requirements
Module: spec_global_history

Interface
REQ-001 SHALL have parameter HIST_W, default 8: history length in bits, legal range 2..32.
REQ-002 SHALL have parameter CKPT_DEPTH, default 4: number of in-flight branch checkpoints, power of two, legal range 2..16.
REQ-003 SHALL have port clk, input, 1: clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port predict_valid, input, 1: fetch issues a branch prediction this cycle.
REQ-006 SHALL have port predict_taken, input, 1: predicted direction.
REQ-007 SHALL have port predict_ready, output, 1: a checkpoint slot is free; combinational, equal to (ckpt_count != CKPT_DEPTH).
REQ-008 SHALL have port resolve_valid, input, 1: the oldest in-flight branch resolves this cycle; resolution is in program order.
REQ-009 SHALL have port resolve_taken, input, 1: actual direction of the resolving branch.
REQ-010 SHALL have port resolve_mispredict, input, 1: the resolving branch was mispredicted.
REQ-011 SHALL have port flush, input, 1: exception or pipeline flush.
REQ-012 SHALL have port hist, output, HIST_W: speculative history, registered.
REQ-013 SHALL have port commit_hist, output, HIST_W: architectural (retired) history, registered.
REQ-014 SHALL have port ckpt_count, output, $clog2(CKPT_DEPTH)+1: number of occupied checkpoints.
REQ-015 SHALL have port err_underflow, output, 1: sticky flag set when resolve_valid is asserted while ckpt_count==0.

Function
REQ-016 An accepted predict (predict_valid && predict_ready) SHALL push the current hist into the checkpoint FIFO and update hist <= {hist[HIST_W-2:0], predict_taken}.
REQ-017 A predict with predict_ready==0 SHALL be ignored: hist and FIFO unchanged.
REQ-018 A resolve with ckpt_count>0 SHALL pop the oldest checkpoint and update commit_hist <= {commit_hist[HIST_W-2:0], resolve_taken}.
REQ-019 A resolve with resolve_mispredict=1 SHALL set hist <= {popped_ckpt[HIST_W-2:0], resolve_taken}, empty the FIFO (ckpt_count=0) and discard any same-cycle predict.
REQ-020 A simultaneous correct resolve and accepted predict SHALL perform both; ckpt_count is unchanged; predict_ready evaluated before the pop (full FIFO blocks the predict).
REQ-021 A resolve with ckpt_count==0 SHALL leave all history and FIFO state unchanged and set err_underflow.
REQ-022 flush SHALL take priority over predict and resolve: hist <= commit_hist, FIFO emptied, commit_hist unchanged.
REQ-023 FIFO read/write pointers SHALL wrap modulo CKPT_DEPTH; latency from input to hist/commit_hist is exactly one cycle.

Reset
REQ-024 Asserting reset SHALL asynchronously clear hist, commit_hist, ckpt_count, pointers and err_underflow to 0, including mid-operation; predict_ready is 1 after reset.
REQ-025 err_underflow SHALL be cleared only by reset.

Structure
REQ-026 Default HIST_W, CKPT_DEPTH and the count width function SHALL reside in shared package ghr_pkg.
REQ-027 Checkpoint storage SHALL be a sub-module ghr_ckpt_fifo (push, pop, clear, head data, count); history shift and recovery logic stay in the top module.

Verification (HIST_W=8, CKPT_DEPTH=4)
REQ-028 Reset, then idle -> hist=0x00, commit_hist=0x00, ckpt_count=0, predict_ready=1, err_underflow=0.
REQ-029 Predicts T,T,N from 0x00 -> hist=0x06, ckpt_count=3; fourth predict T -> hist=0x0D, predict_ready=0; fifth predict ignored, hist stays 0x0D.
REQ-030 From hist=0x06 (3 checkpoints, oldest 0x00), resolve_mispredict with resolve_taken=0 -> hist=0x00, commit_hist=0x00, ckpt_count=0.
REQ-031 ckpt_count=2, correct resolve taken=1 plus predict taken=1 in same cycle -> ckpt_count=2, hist and commit_hist each shifted left with 1 inserted.
REQ-032 commit_hist=0x01, hist=0x0D, flush with simultaneous predict -> hist=0x01, ckpt_count=0, predict dropped.
REQ-033 Resolve with ckpt_count=0 -> err_underflow=1, stays 1 through later traffic until reset; reset asserted mid-burst -> all outputs 0 immediately.
